muldiv_sched: RTL
=================

Name: muldiv_sched

Overview:
- Multi-cycle multiply/divide sequencer for the execute stage.
- Accepts a MULT/MULTU/DIV/DIVU request from the E stage, runs an internal radix-2 restoring divider or a registered multiplier, and holds the pipeline through stall_req until the result is ready.
- Delivers a 64-bit {hi, lo} result that the HILO write path consumes.
- Supports abort on pipeline flush (exception or eret).

Parameters:
- MUL_LAT, 2: cycles spent in MUL state; must be at least 1.
- DIV_ITER, 32: divider iterations, one quotient bit per cycle; fixed at 32 for 32-bit operands.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous reset, active-low.
- start, input, 1: request valid. Held high by the E stage while the instruction sits in E, because stallE keeps it there.
- op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- srca, input, 32: multiplicand or dividend (rs).
- srcb, input, 32: multiplier or divisor (rt).
- cancel, input, 1: flushE; aborts any operation.
- stall_req, output, 1: pipeline hold request; ORed into stallF/D/E by the hazard unit.
- result_valid, output, 1: one-cycle pulse; hi/lo valid in that cycle.
- hi, output, 32: remainder (div) or product[63:32] (mul).
- lo, output, 32: quotient (div) or product[31:0] (mul).

Behaviour:
- Reset (rst=0, asynchronous) sets: state IDLE, counter 0, hi=0, lo=0, result_valid=0, stall_req=0, and clears all operand and partial registers. Reset mid-operation abandons the operation with no output.
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and cancel=0: capture srca, srcb and op; go to DIV if op[1]=1, else MUL.
  - Capture happens in the same cycle as the IDLE→MUL/DIV transition.
- MUL:
  - Entry cycle computes the 64-bit product: signed for MULT, unsigned for MULTU.
  - The product is registered and held for MUL_LAT cycles in total, then DONE.
  - With start sampled in cycle t, DONE occurs in cycle t+1+MUL_LAT.
- DIV:
  - Work on magnitudes: signed ops take two's-complement absolute values, unsigned ops take raw values.
  - Each cycle does one restoring step on a 33-bit partial remainder and shifts one quotient bit in.
  - After DIV_ITER steps (counter 0..31) go to DONE. With start in cycle t, DONE is in cycle t+33.
  - Signed sign fix-up, applied when latching the result: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) yields lo=0x80000000, hi=0. This is the natural wrap; it raises no exception.
  - Divisor 0: no early exit and full latency. Result is lo=0xFFFFFFFF and hi=srca (raw), with no sign fix-up, for both DIV and DIVU.
- DONE:
  - hi/lo update on entry; result_valid=1 for exactly this cycle; stall_req=0, so the pipeline advances.
  - start is ignored in DONE, since it still reflects the completing instruction.
  - Next state is always IDLE.
- hi/lo hold their last value in all other states, including after cancel.
- stall_req is combinational and only ever high while cancel=0:
  - high when state=IDLE, start=1 and cancel=0;
  - high when state is MUL or DIV and cancel=0;
  - low in all other cases.
- cancel has priority over everything:
  - cancel=1 in any state forces stall_req=0 in the same cycle and next state IDLE.
  - result_valid is not asserted and hi/lo are unchanged.
  - cancel in the DONE cycle does not suppress that cycle's result_valid, because the result was already latched.
- Back-to-back operations: a new start in the cycle after DONE (state IDLE) begins a fresh operation with the full latency again.

Test Plan:
- DIVU srca=7, srcb=2, start at t → stall_req=1 during t..t+32; at t+33 result_valid=1, lo=3, hi=1, stall_req=0.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 → at t+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF × 2 → at t+3 result_valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7 with cancel=1 at t+10:
  - stall_req=0 in t+10 and state IDLE at t+11;
  - no result_valid; hi/lo keep their prior values;
  - a following DIVU 9/3 started at t+11 gives lo=3, hi=0 at t+44.
- DIVU 5/0 → at t+33 lo=0xFFFFFFFF, hi=5.
- Drive rst=0 asynchronously at t+5 of a DIV → outputs 0 immediately; after release, no result_valid until a new start.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// Handshake bundle between the E stage and the multiply/divide sequencer.
interface muldiv_sched_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        cancel;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, srca, srcb, cancel,
                  input  stall_req, result_valid, hi, lo);
  modport slave  (input  start, op, srca, srcb, cancel,
                  output stall_req, result_valid, hi, lo);
endinterface

// File: rtl/muldiv_sched.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: registered multiplier plus a
// radix-2 restoring divider; holds the pipeline through stall_req.
module muldiv_sched #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input logic clk,
  input logic rst,
  muldiv_sched_if.slave bus
);
  localparam int CW = $clog2((DIV_ITER > MUL_LAT ? DIV_ITER : MUL_LAT) + 1) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          opSigned;
  logic [31:0]   aReg, bReg;
  logic [63:0]   prodReg;
  logic [32:0]   remReg;
  logic [31:0]   quoReg;
  logic [31:0]   hiReg, loReg;
  logic          rvReg;

  logic        aNeg, bNeg;
  logic [31:0] dvsr;
  logic [63:0] aExt, bExt, prodComb;
  logic [32:0] trial, sub, nextRem;
  logic        qBit;
  logic [31:0] nextQuo, quoFix, remFix;
  logic [31:0] capMag;

  assign aNeg = opSigned & aReg[31];
  assign bNeg = opSigned & bReg[31];
  assign dvsr = bNeg ? -bReg : bReg;

  // Low 64 bits of the product of sign/zero-extended operands is the exact
  // 64-bit product for both signed and unsigned forms.
  assign aExt     = opSigned ? {{32{aReg[31]}}, aReg} : {32'b0, aReg};
  assign bExt     = opSigned ? {{32{bReg[31]}}, bReg} : {32'b0, bReg};
  assign prodComb = aExt * bExt;

  // quoReg starts as the dividend magnitude and quotient bits shift in behind it.
  assign trial   = {remReg[31:0], quoReg[31]};
  assign sub     = trial - {1'b0, dvsr};
  assign qBit    = ~sub[32];
  assign nextRem = qBit ? sub : trial;
  assign nextQuo = {quoReg[30:0], qBit};
  assign quoFix  = (aNeg ^ bNeg) ? -nextQuo : nextQuo;
  assign remFix  = aNeg ? -nextRem[31:0] : nextRem[31:0];

  assign capMag = (~bus.op[0] & bus.srca[31]) ? -bus.srca : bus.srca;

  assign bus.stall_req    = ~bus.cancel &
                            ((state == IDLE && bus.start) || state == MUL || state == DIV);
  assign bus.result_valid = rvReg;
  assign bus.hi           = hiReg;
  assign bus.lo           = loReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      opSigned <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      prodReg  <= '0;
      remReg   <= '0;
      quoReg   <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      rvReg    <= 1'b0;
    end else begin
      rvReg <= 1'b0;
      if (bus.cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            opSigned <= ~bus.op[0];
            aReg     <= bus.srca;
            bReg     <= bus.srcb;
            remReg   <= '0;
            quoReg   <= capMag;
            cnt      <= '0;
            state    <= bus.op[1] ? DIV : MUL;
          end
          MUL: begin
            if (cnt == '0) prodReg <= prodComb;
            if (cnt == CW'(MUL_LAT - 1)) begin
              {hiReg, loReg} <= (cnt == '0) ? prodComb : prodReg;
              rvReg <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DIV: begin
            remReg <= nextRem;
            quoReg <= nextQuo;
            if (cnt == CW'(DIV_ITER - 1)) begin
              // Zero divisor returns all-ones quotient and raw dividend, unfixed.
              if (bReg == '0) begin
                hiReg <= aReg;
                loReg <= '1;
              end else begin
                hiReg <= remFix;
                loReg <= quoFix;
              end
              rvReg <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            cnt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
